// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has absolute priority, while mul/div
// results wait in a small queue and are killed if a younger pipeline write hits the same register.
module wb_arbiter #(
   parameter int unsigned FIFO_DEPTH   = 2,
   parameter int unsigned STARVE_LIMIT = 4,
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [37:0]     wbbus,
   input  logic            md_valid,
   input  logic [4:0]      md_dst,
   input  logic [31:0]     md_data,
   output logic            md_ready,
   input  logic [4:0]      hazard_dst,
   output logic            fifo_hit,
   output logic            stall_req,
   output logic            rf_we,
   output logic [4:0]      rf_waddr,
   output logic [31:0]     rf_wdata,
   output logic [CntW-1:0] fifo_count
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned AgeW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   logic [4:0]            dst_q  [FIFO_DEPTH];
   logic [4:0]            dst_d  [FIFO_DEPTH];
   logic [31:0]           data_q [FIFO_DEPTH];
   logic [31:0]           data_d [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] live_q, live_d;
   logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]       count_q, count_d;
   logic [AgeW-1:0]       age_q, age_d;
   logic                  rf_we_q, rf_we_d;
   logic [4:0]            rf_waddr_q, rf_waddr_d;
   logic [31:0]           rf_wdata_q, rf_wdata_d;

   logic        wb_valid, pipe_wr, head_live, not_empty, push, pop;
   logic [4:0]  wb_dst;
   logic [31:0] wb_data;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign wb_valid  = wbbus[37];
   assign wb_dst    = wbbus[36:32];
   assign wb_data   = wbbus[31:0];
   assign pipe_wr   = wb_valid && (wb_dst != 5'd0);
   assign head_live = live_q[rd_ptr_q];
   assign not_empty = (count_q != '0);
   assign md_ready  = (count_q < CntW'(FIFO_DEPTH));
   assign push      = md_valid && md_ready && (md_dst != 5'd0);
   // A killed head always drains; a live head waits while the pipeline owns the port.
   assign pop       = not_empty && (!head_live || !pipe_wr);

   always_comb begin
      live_d     = live_q;
      dst_d      = dst_q;
      data_d     = data_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      age_d      = age_q;
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;

      if (pipe_wr) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = wb_dst;
         rf_wdata_d = wb_data;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (dst_q[i] == wb_dst) live_d[i] = 1'b0;
         end
      end else if (pop && head_live) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = dst_q[rd_ptr_q];
         rf_wdata_d = data_q[rd_ptr_q];
      end

      if (pop) begin
         live_d[rd_ptr_q] = 1'b0;
         rd_ptr_d         = ptr_inc(rd_ptr_q);
      end
      // Applied after the kill loop so a same-cycle enqueue survives.
      if (push) begin
         live_d[wr_ptr_q] = 1'b1;
         dst_d[wr_ptr_q]  = md_dst;
         data_d[wr_ptr_q] = md_data;
         wr_ptr_d         = ptr_inc(wr_ptr_q);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (pop || !not_empty) begin
         age_d = '0;
      end else if (head_live && (age_q != AgeW'(STARVE_LIMIT))) begin
         age_d = age_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         live_q     <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         age_q      <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         live_q     <= live_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         age_q      <= age_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   // Payload is qualified by the live bits, so it needs no reset.
   always_ff @(posedge clk) begin
      dst_q  <= dst_d;
      data_q <= data_d;
   end

   always_comb begin
      fifo_hit = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (live_q[i] && (dst_q[i] == hazard_dst)) fifo_hit = 1'b1;
      end
      if (hazard_dst == 5'd0) fifo_hit = 1'b0;
   end

   assign stall_req  = (age_q == AgeW'(STARVE_LIMIT));
   assign rf_we      = rf_we_q;
   assign rf_waddr   = rf_waddr_q;
   assign rf_wdata   = rf_wdata_q;
   assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected register-file writes go into a scoreboard queue and a
// negedge monitor pops/compares every write; queue state and flags are checked inline.
module tb_wb_arbiter;

   logic        clk;
   logic        reset;
   logic [37:0] wbbus;
   logic        md_valid;
   logic [4:0]  md_dst;
   logic [31:0] md_data;
   logic        md_ready;
   logic [4:0]  hazard_dst;
   logic        fifo_hit;
   logic        stall_req;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [1:0]  fifo_count;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   wb_arbiter #(
      .FIFO_DEPTH  (2),
      .STARVE_LIMIT(4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .wbbus     (wbbus),
      .md_valid  (md_valid),
      .md_dst    (md_dst),
      .md_data   (md_data),
      .md_ready  (md_ready),
      .hazard_dst(hazard_dst),
      .fifo_hit  (fifo_hit),
      .stall_req (stall_req),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .fifo_count(fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic cyc(input logic wv, input logic [4:0] wd, input logic [31:0] wdat,
                      input logic mv, input logic [4:0] mdst, input logic [31:0] mdat);
      wbbus    = {wv, wd, wdat};
      md_valid = mv;
      md_dst   = mdst;
      md_data  = mdat;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
   endtask

   task automatic hit(input string name, input logic [4:0] d, input logic e);
      hazard_dst = d;
      #1;
      chk(name, {31'b0, fifo_hit}, {31'b0, e});
   endtask

   // Monitor: every write the DUT presents must match the oldest expected write.
   always @(negedge clk) begin
      if (reset === 1'b1 && rf_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write at %0t",
                     rf_waddr, rf_wdata, $time);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", {27'b0, rf_waddr}, {27'b0, e.a});
            chk("wr_data", rf_wdata, e.d);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b0;
      wbbus      = '0;
      md_valid   = 1'b0;
      md_dst     = '0;
      md_data    = '0;
      hazard_dst = 5'd0;
      #12;
      chk("rst_we", {31'b0, rf_we}, 32'd0);
      chk("rst_waddr", {27'b0, rf_waddr}, 32'd0);
      chk("rst_wdata", rf_wdata, 32'd0);
      chk("rst_count", {30'b0, fifo_count}, 32'd0);
      chk("rst_md_ready", {31'b0, md_ready}, 32'd1);
      chk("rst_stall", {31'b0, stall_req}, 32'd0);
      hit("rst_hit", 5'd7, 1'b0);
      @(negedge clk);
      reset = 1'b1;

      // Pipeline-only writes, dst 0 suppressed, address/data hold.
      expect_wr(5'd5, 32'hDEADBEEF);
      cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
      cyc(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'h0);
      chk("dst0_we", {31'b0, rf_we}, 32'd0);
      chk("hold_waddr", {27'b0, rf_waddr}, 32'd5);
      chk("hold_wdata", rf_wdata, 32'hDEADBEEF);

      // Idle md result: enqueue edge, then write edge.
      expect_wr(5'd7, 32'h11);
      cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h11);
      chk("md_enq_count", {30'b0, fifo_count}, 32'd1);
      chk("md_enq_we", {31'b0, rf_we}, 32'd0);
      hit("md_hit7", 5'd7, 1'b1);
      idle();
      chk("md_drain_count", {30'b0, fifo_count}, 32'd0);

      // Full queue under continuous pipeline traffic, starvation stall, one bubble.
      expect_wr(5'd1, 32'h100);
      cyc(1'b1, 5'd1, 32'h100, 1'b1, 5'd10, 32'hA0);
      expect_wr(5'd2, 32'h200);
      cyc(1'b1, 5'd2, 32'h200, 1'b1, 5'd11, 32'hB1);
      chk("full_count", {30'b0, fifo_count}, 32'd2);
      chk("full_md_ready", {31'b0, md_ready}, 32'd0);
      expect_wr(5'd3, 32'h300);
      cyc(1'b1, 5'd3, 32'h300, 1'b1, 5'd12, 32'hC2);
      expect_wr(5'd4, 32'h400);
      cyc(1'b1, 5'd4, 32'h400, 1'b1, 5'd12, 32'hC2);
      chk("stall_early", {31'b0, stall_req}, 32'd0);
      expect_wr(5'd5, 32'h500);
      cyc(1'b1, 5'd5, 32'h500, 1'b1, 5'd12, 32'hC2);
      chk("stall_set", {31'b0, stall_req}, 32'd1);
      chk("held_count", {30'b0, fifo_count}, 32'd2);
      expect_wr(5'd10, 32'hA0);
      cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC2);
      chk("stall_clear", {31'b0, stall_req}, 32'd0);
      chk("bubble_count", {30'b0, fifo_count}, 32'd1);
      expect_wr(5'd11, 32'hB1);
      cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC2);
      chk("pushpop_count", {30'b0, fifo_count}, 32'd1);
      expect_wr(5'd12, 32'hC2);
      idle();
      chk("full_drain_count", {30'b0, fifo_count}, 32'd0);

      // Kill: younger pipeline write wins, killed head pops even during a pipeline write.
      cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hAA);
      hit("kill_hit_before", 5'd9, 1'b1);
      expect_wr(5'd9, 32'hBB);
      cyc(1'b1, 5'd9, 32'hBB, 1'b0, 5'd0, 32'h0);
      hit("kill_hit_after", 5'd9, 1'b0);
      chk("killed_count", {30'b0, fifo_count}, 32'd1);
      expect_wr(5'd6, 32'h66);
      cyc(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0);
      chk("killed_pop_count", {30'b0, fifo_count}, 32'd0);
      idle();

      // Same-cycle enqueue and pipeline write to the same register: entry survives.
      expect_wr(5'd3, 32'h3B);
      expect_wr(5'd3, 32'h33);
      cyc(1'b1, 5'd3, 32'h3B, 1'b1, 5'd3, 32'h33);
      hit("survive_hit", 5'd3, 1'b1);
      hit("hit_dst0", 5'd0, 1'b0);
      idle();
      chk("survive_count", {30'b0, fifo_count}, 32'd0);

      // md result to r0 is consumed without queuing.
      cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h77);
      chk("md_dst0_count", {30'b0, fifo_count}, 32'd0);

      // Asynchronous reset with two entries queued discards them.
      expect_wr(5'd1, 32'h1111);
      cyc(1'b1, 5'd1, 32'h1111, 1'b1, 5'd20, 32'h14);
      expect_wr(5'd2, 32'h2222);
      cyc(1'b1, 5'd2, 32'h2222, 1'b1, 5'd21, 32'h15);
      chk("pre_rst_count", {30'b0, fifo_count}, 32'd2);
      wbbus    = '0;
      md_valid = 1'b0;
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_we", {31'b0, rf_we}, 32'd0);
      chk("arst_waddr", {27'b0, rf_waddr}, 32'd0);
      chk("arst_wdata", rf_wdata, 32'd0);
      chk("arst_count", {30'b0, fifo_count}, 32'd0);
      chk("arst_md_ready", {31'b0, md_ready}, 32'd1);
      hit("arst_hit", 5'd20, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      idle();
      idle();
      idle();
      chk("post_rst_count", {30'b0, fifo_count}, 32'd0);

      // First write right after reset release.
      @(negedge clk);
      reset = 1'b0;
      #2;
      reset = 1'b1;
      expect_wr(5'd8, 32'h88);
      cyc(1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 32'h0);
      chk("first_we", {31'b0, rf_we}, 32'd1);
      idle();
      idle();
      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
